// File: rtl/branch_checkpoint_stack_pkg.sv
// Shared sizing constants and types for the branch checkpoint stack.
package branch_checkpoint_stack_pkg;

  localparam int unsigned PHYS_REG_SZ_R10K = 64;
  localparam int unsigned PHYS_REG_IDX_W   = $clog2(PHYS_REG_SZ_R10K);
  localparam int unsigned N                = 2;
  localparam int unsigned NUM_SCALAR_BITS  = $clog2(N + 1);
  localparam int unsigned BS_DEPTH         = 8;

  typedef logic [$clog2(BS_DEPTH)-1:0] BS_IDX;

  typedef struct packed {
    logic                        valid;
    logic [PHYS_REG_SZ_R10K-1:0] snapshot;
  } BS_ENTRY;

endpackage

// File: rtl/branch_checkpoint_stack.sv
// Free-list checkpoint stack for in-flight branches; drives the free-list restore
// path on a mispredict and keeps stored snapshots current with retiring T_old registers.
module branch_checkpoint_stack
  import branch_checkpoint_stack_pkg::*;
#(
  parameter int unsigned DEPTH     = BS_DEPTH,
  parameter int unsigned PHYS_REGS = PHYS_REG_SZ_R10K
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  push_valid,
  input  logic [PHYS_REGS-1:0]                  push_free_list,
  output logic [$clog2(DEPTH)-1:0]              push_tag,
  output logic                                  full,
  output logic [$clog2(DEPTH):0]                count,
  input  logic [N-1:0][$clog2(PHYS_REGS)-1:0]   phys_regs_retiring,
  input  logic [NUM_SCALAR_BITS-1:0]            num_retiring_valid,
  input  logic                                  resolve_valid,
  input  logic [$clog2(DEPTH)-1:0]              resolve_tag,
  input  logic                                  resolve_mispredict,
  output logic                                  restore_flag,
  output logic [PHYS_REGS-1:0]                  free_list_restore,
  output logic [DEPTH-1:0]                      squash_mask
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic                 valid;
    logic [PHYS_REGS-1:0] snapshot;
  } entry_t;

  entry_t               entries [DEPTH];
  ptr_t                 head;
  ptr_t                 tail;
  ptr_t                 occupancy;
  ptr_t                 tag_ptr;
  ptr_t                 squash_len;
  idx_t                 head_idx;
  idx_t                 tail_idx;
  idx_t                 off;
  logic [PHYS_REGS-1:0] retire_vec;
  logic [DEPTH-1:0]     squash;
  logic                 mispredict;
  logic                 correct_fire;
  logic                 push_fire;

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign occupancy = tail - head;
  assign count     = occupancy;
  assign full      = (occupancy == PTR_W'(DEPTH));
  assign push_tag  = tail_idx;

  assign mispredict   = resolve_valid & resolve_mispredict & entries[resolve_tag].valid;
  assign correct_fire = resolve_valid & ~resolve_mispredict & entries[resolve_tag].valid;
  assign push_fire    = push_valid & ~full & ~(resolve_valid & resolve_mispredict);

  always_comb begin
    retire_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i < int'(num_retiring_valid)) retire_vec[phys_regs_retiring[i]] = 1'b1;
    end
  end

  // Rebuild the tag's full pointer (with wrap bit) from its distance past head, so
  // the rewound tail never leaves count above DEPTH.
  always_comb begin
    tag_ptr    = head + PTR_W'(idx_t'(resolve_tag - head_idx));
    squash_len = tail - tag_ptr;
    squash     = '0;
    off        = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      off = idx_t'(j) - resolve_tag;
      if (mispredict && (PTR_W'(off) < squash_len)) squash[j] = 1'b1;
    end
  end

  assign restore_flag      = mispredict;
  assign free_list_restore = mispredict ? entries[resolve_tag].snapshot : '0;
  assign squash_mask       = squash;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) entries[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (entries[j].valid && !squash[j])
          entries[j].snapshot <= entries[j].snapshot | retire_vec;
        if (squash[j]) entries[j].valid <= 1'b0;
      end
      if (correct_fire) entries[resolve_tag].valid <= 1'b0;
      if (push_fire) begin
        entries[tail_idx].valid    <= 1'b1;
        entries[tail_idx].snapshot <= push_free_list | retire_vec;
        tail                       <= tail + 1'b1;
      end else if (mispredict) begin
        tail <= tag_ptr;
      end
      if ((occupancy != '0) && !entries[head_idx].valid) head <= head + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Directed bench for branch_checkpoint_stack: push/resolve/restore scenarios with hand-computed expectations.
module tb_branch_checkpoint_stack;
  import branch_checkpoint_stack_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            push_valid;
  logic [63:0]     push_free_list;
  logic [2:0]      push_tag;
  logic            full;
  logic [3:0]      count;
  logic [1:0][5:0] phys_regs_retiring;
  logic [1:0]      num_retiring_valid;
  logic            resolve_valid;
  logic [2:0]      resolve_tag;
  logic            resolve_mispredict;
  logic            restore_flag;
  logic [63:0]     free_list_restore;
  logic [7:0]      squash_mask;

  int errors = 0;
  int checks = 0;
  int drops  = 0;

  branch_checkpoint_stack #(.DEPTH(8), .PHYS_REGS(64)) dut (
    .clock              (clock),
    .reset              (reset),
    .push_valid         (push_valid),
    .push_free_list     (push_free_list),
    .push_tag           (push_tag),
    .full               (full),
    .count              (count),
    .phys_regs_retiring (phys_regs_retiring),
    .num_retiring_valid (num_retiring_valid),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .restore_flag       (restore_flag),
    .free_list_restore  (free_list_restore),
    .squash_mask        (squash_mask)
  );

  always #5 clock = ~clock;

  // Pushes offered while full are dropped by the design; tally them to check against the scenario.
  always @(posedge clock)
    if (reset && push_valid && full && !(resolve_valid && resolve_mispredict)) drops++;

  task automatic clr();
    push_valid         = 1'b0;
    push_free_list     = '0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    resolve_tag        = '0;
    num_retiring_valid = '0;
    phys_regs_retiring = '0;
  endtask

  task automatic idle();
    @(negedge clock); clr(); #1;
  endtask

  task automatic drive_push(input logic [63:0] fl);
    @(negedge clock); clr(); push_valid = 1'b1; push_free_list = fl; #1;
  endtask

  task automatic drive_resolve(input logic [2:0] tag, input logic mp);
    @(negedge clock); clr(); resolve_valid = 1'b1; resolve_tag = tag; resolve_mispredict = mp; #1;
  endtask

  task automatic do_reset();
    @(negedge clock); clr(); reset = 1'b0;
    @(negedge clock); reset = 1'b1; #1;
  endtask

  task automatic test_reset();
    clr(); reset = 1'b0;
    @(negedge clock); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (push_tag !== 3'd0) begin errors++; $display("FAIL reset_push_tag got=%0d exp=0", push_tag); end
    checks++; if (restore_flag !== 1'b0 || free_list_restore !== 64'h0 || squash_mask !== 8'h0) begin
      errors++; $display("FAIL reset_restore got=%0b/%h/%h exp=0/0/0", restore_flag, free_list_restore, squash_mask);
    end
    reset = 1'b1;
  endtask

  task automatic test_push();
    logic [63:0] fls [3];
    fls[0] = 64'hF0; fls[1] = 64'hE0; fls[2] = 64'hC0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_push(fls[i]);
      checks++; if (push_tag !== 3'(i)) begin errors++; $display("FAIL push_tag%0d got=%0d exp=%0d", i, push_tag, i); end
    end
    idle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL push_count got=%0d exp=3", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL push_full got=%0b exp=0", full); end
  endtask

  task automatic test_retire_merge();
    do_reset();
    drive_push(64'h0F);
    drive_push(64'hFF);
    @(negedge clock); clr(); num_retiring_valid = 2'd1; phys_regs_retiring[0] = 6'd5; phys_regs_retiring[1] = 6'd9; #1;
    idle();
    drive_resolve(3'd0, 1'b1);
    checks++; if (restore_flag !== 1'b1) begin errors++; $display("FAIL merge_flag got=%0b exp=1", restore_flag); end
    checks++; if (free_list_restore !== 64'h2F) begin errors++; $display("FAIL merge_fl got=%h exp=2f", free_list_restore); end
    checks++; if (squash_mask !== 8'h03) begin errors++; $display("FAIL merge_squash got=%h exp=03", squash_mask); end
    idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL merge_count got=%0d exp=0", count); end
    // Same-cycle retire folds into the pushed snapshot; num_retiring_valid=0 adds nothing.
    @(negedge clock); clr(); push_valid = 1'b1; push_free_list = 64'h0;
    num_retiring_valid = 2'd2; phys_regs_retiring[0] = 6'd1; phys_regs_retiring[1] = 6'd3; #1;
    checks++; if (push_tag !== 3'd0) begin errors++; $display("FAIL merge_push_tag got=%0d exp=0", push_tag); end
    @(negedge clock); clr(); num_retiring_valid = 2'd0; phys_regs_retiring[0] = 6'd9; #1;
    drive_resolve(3'd0, 1'b1);
    checks++; if (free_list_restore !== 64'h0A) begin errors++; $display("FAIL merge_same_cycle got=%h exp=0a", free_list_restore); end
    idle();
  endtask

  task automatic test_out_of_order_resolve();
    do_reset();
    for (int i = 0; i < 4; i++) drive_push(64'h1 << i);
    drive_resolve(3'd2, 1'b0);
    checks++; if (restore_flag !== 1'b0) begin errors++; $display("FAIL ooo_no_restore got=%0b exp=0", restore_flag); end
    drive_resolve(3'd0, 1'b0);
    idle();
    idle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL ooo_count_a got=%0d exp=3", count); end
    idle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL ooo_count_b got=%0d exp=3", count); end
    drive_resolve(3'd1, 1'b0);
    idle(); idle(); idle(); idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL ooo_drain got=%0d exp=1", count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) drive_push(64'(i + 1) << 8);
    drive_push(64'hDEAD);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%0b exp=1", full); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
    drive_push(64'hBEEF);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_hold got=%0d exp=8", count); end
    drive_resolve(3'd5, 1'b1);
    checks++; if (squash_mask !== 8'hE0) begin errors++; $display("FAIL full_squash got=%h exp=e0", squash_mask); end
    checks++; if (free_list_restore !== 64'h600) begin errors++; $display("FAIL full_fl got=%h exp=600", free_list_restore); end
    idle();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL full_after got=%0d exp=5", count); end
    checks++; if (drops !== 2) begin errors++; $display("FAIL full_drops got=%0d exp=2", drops); end
  endtask

  task automatic test_wrap();
    logic [63:0] fls [4];
    logic [2:0]  tags [4];
    fls[0] = 64'hA6; fls[1] = 64'hA7; fls[2] = 64'hA0; fls[3] = 64'hA1;
    tags[0] = 3'd6; tags[1] = 3'd7; tags[2] = 3'd0; tags[3] = 3'd1;
    do_reset();
    for (int i = 0; i < 6; i++) drive_push(64'h1);
    for (int i = 0; i < 6; i++) drive_resolve(3'(i), 1'b0);
    for (int i = 0; i < 8; i++) idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    for (int i = 0; i < 4; i++) begin
      drive_push(fls[i]);
      checks++; if (push_tag !== tags[i]) begin errors++; $display("FAIL wrap_tag%0d got=%0d exp=%0d", i, push_tag, tags[i]); end
    end
    drive_resolve(3'd7, 1'b1);
    checks++; if (squash_mask !== 8'h83) begin errors++; $display("FAIL wrap_squash got=%h exp=83", squash_mask); end
    checks++; if (free_list_restore !== 64'hA7) begin errors++; $display("FAIL wrap_fl got=%h exp=a7", free_list_restore); end
    idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", count); end
    checks++; if (push_tag !== 3'd7) begin errors++; $display("FAIL wrap_tail got=%0d exp=7", push_tag); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_push(64'h11);
    drive_push(64'h22);
    @(negedge clock); clr(); push_valid = 1'b1; push_free_list = 64'h44;
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 3'd1; #1;
    checks++; if (restore_flag !== 1'b1 || free_list_restore !== 64'h22 || squash_mask !== 8'h02) begin
      errors++; $display("FAIL b2b_restore got=%0b/%h/%h exp=1/22/02", restore_flag, free_list_restore, squash_mask);
    end
    idle();
    checks++; if (count !== 4'd1 || push_tag !== 3'd1) begin
      errors++; $display("FAIL b2b_push_dropped got=%0d/%0d exp=1/1", count, push_tag);
    end
    drive_resolve(3'd5, 1'b1);
    checks++; if (restore_flag !== 1'b0 || squash_mask !== 8'h00 || free_list_restore !== 64'h0) begin
      errors++; $display("FAIL invalid_tag got=%0b/%h/%h exp=0/00/0", restore_flag, squash_mask, free_list_restore);
    end
    idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL invalid_tag_count got=%0d exp=1", count); end
    drive_push(64'h33);
    @(negedge clock); clr(); resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 3'd0; #1;
    checks++; if (restore_flag !== 1'b1) begin errors++; $display("FAIL pre_reset_flag got=%0b exp=1", restore_flag); end
    #2 reset = 1'b0; #1;
    checks++; if (restore_flag !== 1'b0 || free_list_restore !== 64'h0 || squash_mask !== 8'h0) begin
      errors++; $display("FAIL async_reset_restore got=%0b/%h/%h exp=0/0/0", restore_flag, free_list_restore, squash_mask);
    end
    checks++; if (count !== 4'd0 || full !== 1'b0 || push_tag !== 3'd0) begin
      errors++; $display("FAIL async_reset_ptrs got=%0d/%0b/%0d exp=0/0/0", count, full, push_tag);
    end
    @(negedge clock); clr(); reset = 1'b1; #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    test_reset();
    test_push();
    test_retire_merge();
    test_out_of_order_resolve();
    test_full();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
